// File: rtl/nn_readout_pkg.sv
// rtl/nn_readout_pkg.sv - shared widths, FSM states and score type for the readout accumulator
package nn_readout_pkg;

  localparam int DEF_SCORE_W = 18;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_DROP_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  typedef logic signed [DEF_SCORE_W-1:0] score_t;

endpackage

// File: rtl/nn_score_slicer.sv
// rtl/nn_score_slicer.sv - signed score vs threshold slicer; decision is forced low without valid
module nn_score_slicer #(
  parameter int W = 18
) (
  input  logic signed [W-1:0] i_score,
  input  logic signed [W-1:0] i_threshold,
  input  logic                i_valid,
  output logic                o_decision
);

  // a score equal to the threshold is an excited shot
  assign o_decision = i_valid & (i_score >= i_threshold);

endmodule

// File: rtl/nn_readout_accum.sv
// rtl/nn_readout_accum.sv - run accumulator: slices NN scores, counts shots/ones, reports via valid/ready
// Optional running score sum output behind NN_READOUT_SCORE_SUM_EN.
module nn_readout_accum
  import nn_readout_pkg::*;
#(
  parameter int SCORE_W = DEF_SCORE_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DROP_W  = DEF_DROP_W
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   cfg_shots,
  input  logic [SCORE_W-1:0] cfg_threshold,
  input  logic [SCORE_W-1:0] score_V,
  input  logic               score_V_ap_vld,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [CNT_W-1:0]   ones_count,
  output logic [CNT_W-1:0]   shot_count,
  output logic               last_state,
  output logic [DROP_W-1:0]  drop_count
`ifdef NN_READOUT_SCORE_SUM_EN
  ,
  output logic signed [SCORE_W+CNT_W-1:0] score_sum
`endif
);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [CNT_W-1:0]          r_shots;
  logic signed [SCORE_W-1:0] r_thr;
  logic [CNT_W-1:0]          r_ones;
  logic [CNT_W-1:0]          r_shot_cnt;
  logic                      r_last;
  logic [DROP_W-1:0]         r_drop;

  logic                      w_start_ok;
  logic                      w_accept;
  logic                      w_drop;
  logic                      w_dec;
  logic [CNT_W-1:0]          w_shot_next;

  assign w_start_ok  = (r_state == ST_IDLE) && start;
  assign w_accept    = (r_state == ST_ACCUM) && score_V_ap_vld;
  // no backpressure upstream, so anything outside ACCUM is lost and counted
  assign w_drop      = score_V_ap_vld && (r_state != ST_ACCUM);
  assign w_shot_next = r_shot_cnt + CNT_W'(1);

  nn_score_slicer #(
    .W(SCORE_W)
  ) u_slicer (
    .i_score     (score_V),
    .i_threshold (r_thr),
    .i_valid     (w_accept),
    .o_decision  (w_dec)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (cfg_shots != '0) ? ST_ACCUM : ST_REPORT;
        end
      end
      ST_ACCUM: begin
        if (score_V_ap_vld && (w_shot_next == r_shots)) begin
          w_next_state = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (result_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_shots    <= '0;
      r_thr      <= '0;
      r_ones     <= '0;
      r_shot_cnt <= '0;
      r_last     <= 1'b0;
      r_drop     <= '0;
    end else begin
      if (w_start_ok) begin
        r_shots    <= cfg_shots;
        r_thr      <= cfg_threshold;
        r_ones     <= '0;
        r_shot_cnt <= '0;
        r_last     <= 1'b0;
      end else if (w_accept) begin
        r_shot_cnt <= w_shot_next;
        r_ones     <= r_ones + CNT_W'(w_dec);
        r_last     <= w_dec;
      end
      if (w_drop && (r_drop != '1)) begin
        r_drop <= r_drop + DROP_W'(1);
      end
    end
  end

`ifdef NN_READOUT_SCORE_SUM_EN
  logic signed [SCORE_W+CNT_W-1:0] r_sum;

  // CNT_W guard bits make overflow impossible for any legal shot count
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_sum <= '0;
    end else if (w_start_ok) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= r_sum + {{CNT_W{score_V[SCORE_W-1]}}, score_V};
    end
  end

  assign score_sum = r_sum;
`endif

  assign busy         = (r_state == ST_ACCUM);
  assign result_valid = (r_state == ST_REPORT);
  assign ones_count   = r_ones;
  assign shot_count   = r_shot_cnt;
  assign last_state   = r_last;
  assign drop_count   = r_drop;

endmodule

// File: tb/tb_nn_readout_accum.sv
// tb/tb_nn_readout_accum.sv - self-checking bench: directed scenarios plus randomized runs vs a shot-list model
module tb_nn_readout_accum;

  localparam int SW = 18;
  localparam int CW = 16;
  localparam int DW = 8;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_shots = '0;
  logic [SW-1:0] cfg_threshold = '0;
  logic [SW-1:0] score_V = '0;
  logic          score_V_ap_vld = 1'b0;
  logic          busy;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [CW-1:0] ones_count;
  logic [CW-1:0] shot_count;
  logic          last_state;
  logic [DW-1:0] drop_count;
`ifdef NN_READOUT_SCORE_SUM_EN
  logic signed [SW+CW-1:0] score_sum;
`endif

  int errors = 0;
  int checks = 0;
  int m_drop = 0;

  always #5 ap_clk = ~ap_clk;

  nn_readout_accum dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .start          (start),
    .cfg_shots      (cfg_shots),
    .cfg_threshold  (cfg_threshold),
    .score_V        (score_V),
    .score_V_ap_vld (score_V_ap_vld),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .ones_count     (ones_count),
    .shot_count     (shot_count),
    .last_state     (last_state),
    .drop_count     (drop_count)
`ifdef NN_READOUT_SCORE_SUM_EN
    ,
    .score_sum      (score_sum)
`endif
  );

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic note_drop();
    if (m_drop < 255) m_drop++;
  endtask

  task automatic do_start(input int n, input int thr);
    cfg_shots     = n[CW-1:0];
    cfg_threshold = thr[SW-1:0];
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  task automatic send(input int s);
    score_V        = s[SW-1:0];
    score_V_ap_vld = 1'b1;
    tick();
    score_V_ap_vld = 1'b0;
  endtask

  task automatic accept_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", result_valid); end
    checks++; if (ones_count !== 16'd0 || shot_count !== 16'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", ones_count, shot_count); end
    checks++; if (last_state !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL reset_last_drop got=%0b/%0d exp=0/0", last_state, drop_count); end
    ap_rst = 1'b0;
    m_drop = 0;
    tick();
  endtask

  task automatic test_basic();
    do_start(4, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%0b exp=1", busy); end
    send(5);
    send(-3);
    send(0);
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%0b exp=0", result_valid); end
    send(100);
    checks++; if (result_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_valid got=%0b busy=%0b exp=1 busy=0", result_valid, busy); end
    checks++; if (ones_count !== 16'd3) begin errors++; $display("FAIL basic_ones got=%0d exp=3", ones_count); end
    checks++; if (shot_count !== 16'd4) begin errors++; $display("FAIL basic_shots got=%0d exp=4", shot_count); end
    checks++; if (last_state !== 1'b1) begin errors++; $display("FAIL basic_last got=%0b exp=1", last_state); end
    accept_result();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_release got=%0b exp=0", result_valid); end
    checks++; if (ones_count !== 16'd3 || shot_count !== 16'd4) begin errors++; $display("FAIL basic_hold_idle got=%0d/%0d exp=3/4", ones_count, shot_count); end
  endtask

  task automatic test_signed();
    do_start(3, -10);
    send(-11);
    send(-10);
    send(-9);
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL signed_valid got=%0b exp=1", result_valid); end
    checks++; if (ones_count !== 16'd2 || shot_count !== 16'd3) begin errors++; $display("FAIL signed_counts got=%0d/%0d exp=2/3", ones_count, shot_count); end
    checks++; if (last_state !== 1'b1) begin errors++; $display("FAIL signed_last got=%0b exp=1", last_state); end
    accept_result();
  endtask

  task automatic test_zero_shots();
    do_start(0, 7);
    checks++; if (result_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_valid got=%0b busy=%0b exp=1 busy=0", result_valid, busy); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (result_valid !== 1'b1 || ones_count !== 16'd0 || shot_count !== 16'd0) begin
        errors++; $display("FAIL zero_hold cyc=%0d got=%0b %0d/%0d exp=1 0/0", i, result_valid, ones_count, shot_count);
      end
    end
    accept_result();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL zero_release got=%0b exp=0", result_valid); end
  endtask

  task automatic test_drop();
    score_V        = 18'd42;
    score_V_ap_vld = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      note_drop();
      if (i == 99) begin
        checks++; if (drop_count !== 8'(m_drop)) begin errors++; $display("FAIL drop_mid got=%0d exp=%0d", drop_count, m_drop); end
      end
    end
    score_V_ap_vld = 1'b0;
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_sat got=%0d exp=255", drop_count); end
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    m_drop = 0;
    score_V        = 18'd50;
    score_V_ap_vld = 1'b1;
    do_start(2, 0);
    score_V_ap_vld = 1'b0;
    note_drop();
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL drop_coincident got=%0d exp=1", drop_count); end
    send(-5);
    checks++; if (result_valid !== 1'b0 || shot_count !== 16'd1) begin errors++; $display("FAIL coincident_first got=%0b %0d exp=0 1", result_valid, shot_count); end
    send(-6);
    checks++; if (result_valid !== 1'b1 || ones_count !== 16'd0 || shot_count !== 16'd2) begin errors++; $display("FAIL coincident_result got=%0b %0d/%0d exp=1 0/2", result_valid, ones_count, shot_count); end
    accept_result();
  endtask

  task automatic test_reset_midrun();
    do_start(10, 0);
    for (int i = 0; i < 4; i++) send(i + 1);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    m_drop = 0;
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL midrst_flags got=%0b/%0b exp=0/0", busy, result_valid); end
    checks++; if (ones_count !== 16'd0 || shot_count !== 16'd0 || last_state !== 1'b0 || drop_count !== 8'd0) begin
      errors++; $display("FAIL midrst_values got=%0d/%0d/%0b/%0d exp=0/0/0/0", ones_count, shot_count, last_state, drop_count);
    end
    tick();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_result got=%0b exp=0", result_valid); end
    do_start(2, 5);
    send(7);
    send(3);
    checks++; if (result_valid !== 1'b1 || ones_count !== 16'd1 || shot_count !== 16'd2 || last_state !== 1'b0) begin
      errors++; $display("FAIL midrst_rerun got=%0b %0d/%0d/%0b exp=1 1/2/0", result_valid, ones_count, shot_count, last_state);
    end
    accept_result();
  endtask

`ifdef NN_READOUT_SCORE_SUM_EN
  task automatic test_score_sum();
    do_start(3, 0);
    send(131071);
    send(131071);
    send(-131072);
    checks++; if (longint'(score_sum) != 64'sd131070) begin errors++; $display("FAIL sum_extreme got=%0d exp=131070", score_sum); end
    accept_result();
  endtask
`endif

  task automatic test_random();
    for (int run = 0; run < 25; run++) begin
      int     n;
      int     thr;
      int     shots[$];
      int     exp_ones;
      int     exp_last;
      longint exp_sum;
      n   = $urandom_range(1, 12);
      thr = int'($urandom_range(0, 2000)) - 1000;
      shots.delete();
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        send(int'($urandom_range(0, 500)));
        note_drop();
      end
      if ($urandom_range(0, 1) == 1) begin
        score_V        = 18'd77;
        score_V_ap_vld = 1'b1;
        note_drop();
      end
      do_start(n, thr);
      score_V_ap_vld = 1'b0;
      for (int i = 0; i < n; i++) begin
        int s;
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          if ($urandom_range(0, 2) == 0) begin
            cfg_shots     = 16'd1;
            cfg_threshold = 18'h1FFFF;
            start         = 1'b1;
          end
          tick();
          start = 1'b0;
          checks++; if (busy !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL rand_accum run=%0d got=%0b/%0b exp=1/0", run, busy, result_valid); end
        end
        s = int'($urandom_range(0, 3000)) - 1500;
        shots.push_back(s);
        send(s);
      end
      exp_ones = 0;
      exp_sum  = 0;
      foreach (shots[j]) begin
        if (shots[j] >= thr) exp_ones++;
        exp_sum += shots[j];
      end
      exp_last = (shots[$] >= thr) ? 1 : 0;
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL rand_valid run=%0d got=%0b exp=1", run, result_valid); end
      checks++; if (ones_count !== 16'(exp_ones) || shot_count !== 16'(n)) begin
        errors++; $display("FAIL rand_counts run=%0d got=%0d/%0d exp=%0d/%0d", run, ones_count, shot_count, exp_ones, n);
      end
      checks++; if (last_state !== 1'(exp_last)) begin errors++; $display("FAIL rand_last run=%0d got=%0b exp=%0d", run, last_state, exp_last); end
`ifdef NN_READOUT_SCORE_SUM_EN
      checks++; if (longint'(score_sum) != exp_sum) begin errors++; $display("FAIL rand_sum run=%0d got=%0d exp=%0d", run, score_sum, exp_sum); end
`endif
      for (int w = $urandom_range(0, 3); w > 0; w--) begin
        if ($urandom_range(0, 1) == 1) begin
          send(int'($urandom_range(0, 100)));
          note_drop();
        end else begin
          tick();
        end
        checks++; if (result_valid !== 1'b1 || ones_count !== 16'(exp_ones)) begin
          errors++; $display("FAIL rand_report_hold run=%0d got=%0b %0d exp=1 %0d", run, result_valid, ones_count, exp_ones);
        end
      end
      accept_result();
      checks++; if (result_valid !== 1'b0 || drop_count !== 8'(m_drop)) begin
        errors++; $display("FAIL rand_release run=%0d got=%0b drop=%0d exp=0 drop=%0d", run, result_valid, drop_count, m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_zero_shots();
    test_drop();
    test_reset_midrun();
`ifdef NN_READOUT_SCORE_SUM_EN
    test_score_sum();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
